fifo_word_reader: RTL and testbench
===================================

FIFO_WORD_READER -- requirements
Module: fifo_word_reader

Interface
REQ-001 SHALL provide parameter BYTE_ORDER, default 0: 0 = first popped byte in out_data[15:8]; 1 = first popped byte in out_data[7:0].
REQ-002 SHALL provide parameter PAD_BYTE, default 8'h00: fill value for the missing byte of a flushed word.
REQ-003 SHALL provide port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL provide port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL provide port fifo_empty, input, 1: FIFO head not valid when 1.
REQ-006 SHALL provide port fifo_data, input, 8: FIFO head byte (look-ahead); valid whenever fifo_empty=0.
REQ-007 SHALL provide port fifo_rd, output, 1: pop strobe; one byte consumed per cycle high.
REQ-008 SHALL provide port flush, input, 1: request to emit a held single byte as a padded word.
REQ-009 SHALL provide port out_valid, output, 1: out_data holds a word.
REQ-010 SHALL provide port out_ready, input, 1: consumer accepts a word when high with out_valid.
REQ-011 SHALL provide port out_data, output, 16: packed word.
REQ-012 SHALL provide port out_partial, output, 1: word carries one real byte plus PAD_BYTE.
REQ-013 SHALL provide port word_count, output, 16: count of accepted words.

Function
REQ-014 SHALL implement FSM states EMPTY (no byte held), HALF (one byte held), WORD (word presented, out_valid=1).
REQ-015 fifo_rd SHALL be combinational: 1 iff fifo_empty=0 and (state=EMPTY, or state=HALF, or state=WORD with out_ready=1).
REQ-016 fifo_rd SHALL never be 1 while fifo_empty=1.
REQ-017 EMPTY with fifo_rd: capture fifo_data as first byte -> HALF.
REQ-018 HALF with fifo_rd: capture fifo_data as second byte, load out_data per BYTE_ORDER, out_partial=0 -> WORD.
REQ-019 HALF, fifo_empty=1, flush=1: load out_data with held byte plus PAD_BYTE per BYTE_ORDER, out_partial=1 -> WORD.
REQ-020 HALF with fifo_empty=0 and flush=1: normal pop SHALL take priority; full word, out_partial=0.
REQ-021 flush SHALL be ignored in EMPTY and WORD.
REQ-022 out_valid SHALL equal (state=WORD), registered.
REQ-023 WORD, out_ready=0: out_data and out_partial SHALL hold stable; no pop.
REQ-024 WORD, out_ready=1, fifo_empty=1: word transferred -> EMPTY.
REQ-025 WORD, out_ready=1, fifo_empty=0: word transferred, new first byte captured -> HALF in the same cycle.
REQ-026 Latency: first-byte pop at cycle N, second at N+1, out_valid=1 at N+2.
REQ-027 Throughput SHALL be one word per 2 cycles with continuous data and out_ready=1.
REQ-028 word_count SHALL increment by 1 on each cycle with out_valid=1 and out_ready=1, and SHALL wrap 16'hFFFF -> 16'h0000.
REQ-029 Partial words SHALL count in word_count like full words.

Reset
REQ-030 rst=1 SHALL immediately force state EMPTY, out_valid=0, out_data=16'h0000, out_partial=0, word_count=0, and discard any held byte.
REQ-031 fifo_rd SHALL be 0 while rst=1.
REQ-032 Reset asserted mid-word (HALF or WORD) SHALL lose that data; the first pop after release starts a new word.

Verification
REQ-033 Reset: rst pulse with fifo_empty=1 -> fifo_rd=0, out_valid=0, out_data=0, word_count=0; stays idle.
REQ-034 Pack: BYTE_ORDER=0, FIFO supplies 8'hA5 then 8'h3C, out_ready=1 -> fifo_rd high two cycles, then out_valid=1, out_data=16'hA53C, out_partial=0, word_count=1; BYTE_ORDER=1 -> 16'h3CA5.
REQ-035 Backpressure: FIFO holds 6 bytes, out_ready=0 for 5 cycles -> exactly 2 pops, out_data stable, fifo_rd=0; on out_ready=1, pop occurs the same cycle and remaining words follow at one per 2 cycles.
REQ-036 Flush: one byte 8'h7E then fifo_empty=1, flush pulse in HALF -> out_data=16'h7E00, out_partial=1; flush in EMPTY -> no output.
REQ-037 Wrap: 65536 accepted words -> word_count returns to 16'h0000; no spurious fifo_rd while fifo_empty=1 at any point.
REQ-038 Async reset in HALF and in WORD, asserted between clock edges -> outputs clear before the next edge; next two bytes form a fresh correct word.

Source files
------------

// File: rtl/fifo_word_reader.sv
// Pops bytes from a look-ahead FIFO and packs them into 16-bit words with a
// valid/ready output; a held lone byte can be flushed out as a padded word.
//
// state | meaning
// EMPTY | no byte held, nothing presented
// HALF  | first byte of a word held
// WORD  | packed word presented on out_data, out_valid=1
module fifo_word_reader #(
  parameter int unsigned BYTE_ORDER = 0,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_partial,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] held_byte;

  function automatic logic [15:0] pack(input logic [7:0] first, input logic [7:0] second);
    return (BYTE_ORDER == 0) ? {first, second} : {second, first};
  endfunction

  // rst gates the strobe so nothing is consumed while the FSM is held in reset
  assign fifo_rd = ~rst & ~fifo_empty & ((state != WORD) | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      held_byte   <= 8'h00;
      out_valid   <= 1'b0;
      out_data    <= 16'h0000;
      out_partial <= 1'b0;
      word_count  <= 16'h0000;
    end else begin
      unique case (state)
        EMPTY: begin
          if (fifo_rd) begin
            held_byte <= fifo_data;
            state     <= HALF;
          end
        end
        HALF: begin
          // a real second byte always beats a flush request
          if (fifo_rd) begin
            out_data    <= pack(held_byte, fifo_data);
            out_partial <= 1'b0;
            out_valid   <= 1'b1;
            state       <= WORD;
          end else if (flush) begin
            out_data    <= pack(held_byte, PAD_BYTE);
            out_partial <= 1'b1;
            out_valid   <= 1'b1;
            state       <= WORD;
          end
        end
        WORD: begin
          if (out_ready) begin
            word_count <= word_count + 16'd1;
            out_valid  <= 1'b0;
            if (fifo_rd) begin
              held_byte <= fifo_data;
              state     <= HALF;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: two instances (both byte orders, different pads)
// checked every cycle against a byte-queue model, plus literal spot checks.
module tb_fifo_word_reader;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        flush;
  logic        out_ready;
  logic        rd0, rd1, v0, v1, p0, p1;
  logic [15:0] d0, d1, c0, c1;

  fifo_word_reader #(.BYTE_ORDER(0), .PAD_BYTE(8'h00)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(rd0), .flush(flush), .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .out_partial(p0), .word_count(c0)
  );

  fifo_word_reader #(.BYTE_ORDER(1), .PAD_BYTE(8'hC3)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(rd1), .flush(flush), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_partial(p1), .word_count(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int pops;
  logic [7:0] src[$];

  // model: at most one held byte, at most one presented word, a wrapping count
  bit          m_have;
  logic [7:0]  m_byte;
  bit          m_valid;
  logic [7:0]  m_first;
  logic [7:0]  m_second;
  bit          m_partial;
  logic [15:0] m_count;
  bit          exp_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_data(input int order, input logic [7:0] pad);
    logic [7:0] sec;
    sec = m_partial ? pad : m_second;
    return (order == 0) ? {m_first, sec} : {sec, m_first};
  endfunction

  task automatic model_reset();
    m_have    = 0;
    m_valid   = 0;
    m_partial = 0;
    m_count   = 16'h0000;
  endtask

  task automatic step(input bit rdy, input bit fl, input bit stall);
    @(negedge clk);
    fifo_empty = (src.size() == 0) || stall;
    fifo_data  = (src.size() != 0) ? src[0] : 8'($urandom);
    out_ready  = rdy;
    flush      = fl;
    #1;
    exp_rd = !fifo_empty && (!m_valid || out_ready);
    chk("fifo_rd0", rd0, exp_rd);
    chk("fifo_rd1", rd1, exp_rd);
    chk("out_valid0", v0, m_valid);
    chk("out_valid1", v1, m_valid);
    chk("word_count0", c0, m_count);
    chk("word_count1", c1, m_count);
    if (m_valid) begin
      chk("out_data0", d0, exp_data(0, 8'h00));
      chk("out_data1", d1, exp_data(1, 8'hC3));
      chk("out_partial0", p0, m_partial);
      chk("out_partial1", p1, m_partial);
    end
    // a presented word leaves first, then the popped byte (if any) is placed
    if (m_valid && out_ready) begin
      m_count++;
      m_valid = 0;
    end
    if (exp_rd) begin
      pops++;
      if (m_have) begin
        m_first   = m_byte;
        m_second  = fifo_data;
        m_partial = 0;
        m_valid   = 1;
        m_have    = 0;
      end else begin
        m_byte = fifo_data;
        m_have = 1;
      end
      src.delete(0);
    end else if (m_have && flush) begin
      m_first   = m_byte;
      m_partial = 1;
      m_valid   = 1;
      m_have    = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    fifo_empty = 1;
    flush      = 0;
    out_ready  = 0;
    fifo_data  = 8'h00;
    rst        = 1;
    #1;
    chk("rst_fifo_rd", rd0, 0);
    chk("rst_out_valid", v0, 0);
    chk("rst_out_data", d0, 16'h0000);
    chk("rst_word_count", c0, 16'h0000);
    chk("rst_out_valid1", v1, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic reset_mid(input bit expect_valid);
    @(negedge clk);
    chk("pre_rst_valid", v0, expect_valid);
    fifo_empty = 0;
    fifo_data  = 8'hEE;
    #2;
    rst = 1;
    #1;
    chk("mid_rst_fifo_rd", rd0, 0);
    chk("mid_rst_out_valid", v0, 0);
    chk("mid_rst_out_data", d0, 16'h0000);
    chk("mid_rst_partial", p0, 0);
    chk("mid_rst_count", c0, 16'h0000);
    model_reset();
    @(posedge clk);
    #2;
    rst        = 0;
    fifo_empty = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; fifo_empty = 1; flush = 0; out_ready = 0; fifo_data = 8'h00;
    n_chk = 0; n_pass = 0; pops = 0;
    model_reset();

    do_reset();
    repeat (3) step(1, 1, 0);
    chk("idle_valid", v0, 0);

    // pack two bytes
    src = '{8'hA5, 8'h3C};
    pops = 0;
    step(1, 0, 0); chk("pack_rd_first", rd0, 1);
    step(1, 0, 0); chk("pack_rd_second", rd0, 1);
    step(1, 0, 0);
    chk("pack_valid", v0, 1);
    chk("pack_data_be", d0, 16'hA53C);
    chk("pack_data_le", d1, 16'h3CA5);
    chk("pack_partial", p0, 0);
    step(1, 0, 0);
    chk("pack_count", c0, 16'd1);
    chk("pack_pops", pops, 2);

    // backpressure
    do_reset();
    src = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    pops = 0;
    repeat (5) step(0, 0, 0);
    chk("bp_pops", pops, 2);
    chk("bp_rd_held", rd0, 0);
    chk("bp_data_stable", d0, 16'h1011);
    step(1, 0, 0);
    chk("bp_release_rd", rd0, 1);
    repeat (5) step(1, 0, 0);
    chk("bp_count", c0, 16'd3);

    // flush of a lone byte, then flush while empty
    do_reset();
    src = '{8'h7E};
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("flush_valid", v0, 1);
    chk("flush_data_be", d0, 16'h7E00);
    chk("flush_data_le", d1, 16'hC37E);
    chk("flush_partial", p0, 1);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("flush_empty_ignored", v0, 0);
    chk("flush_counted", c0, 16'd1);

    // reset while HALF
    do_reset();
    src = '{8'h11};
    step(1, 0, 0);
    reset_mid(0);
    src = '{8'h5A, 8'h69};
    repeat (3) step(1, 0, 0);
    chk("after_half_rst_be", d0, 16'h5A69);
    chk("after_half_rst_le", d1, 16'h695A);

    // reset while WORD
    do_reset();
    src = '{8'h21, 8'h43};
    repeat (3) step(0, 0, 0);
    reset_mid(1);
    src = '{8'h96, 8'h0F};
    repeat (3) step(1, 0, 0);
    chk("after_word_rst_be", d0, 16'h960F);
    chk("after_word_rst_valid", v0, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (src.size() < 6 && ($urandom % 3) != 0) src.push_back(8'($urandom));
      if (($urandom % 500) == 0) do_reset();
      else step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 5) == 0);
    end

    // word_count wrap, starting just below the top
    do_reset();
    src.delete();
    @(negedge clk);
    force dut0.word_count = 16'hFFFD;
    force dut1.word_count = 16'hFFFD;
    #1;
    release dut0.word_count;
    release dut1.word_count;
    m_count = 16'hFFFD;
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    repeat (9) step(1, 0, 0);
    chk("wrap_count0", c0, 16'h0000);
    chk("wrap_count1", c1, 16'h0000);
    repeat (3) step(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
